// File: rtl/pulse_sched.sv
// pulse_sched
// Round-robin burst scheduler. Requesters raise a level request; one at a
// time is granted a burst during which the shared pulse_out holds that
// requester's polarity for max(len,1) cycles. A single GAP cycle with a done
// pulse follows every burst before the next arbitration.
//
// Ports
//   clk       : rising-edge clock for all state
//   rst       : synchronous active-high reset
//   req       : per-requester burst request (level, NREQ bits)
//   mode      : per-requester burst polarity (1 = high burst, 0 = low burst)
//   len       : burst length of the requester being granted (0 counts as 1)
//   gnt       : registered one-hot grant, zero outside a burst
//   pulse_out : shared burst output, straight from a flop
//   busy      : high while a burst or its trailing gap cycle is in progress
//   done      : one-cycle pulse on the cycle following the last burst cycle
module pulse_sched #(
  parameter int NREQ  = 4,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  mode,
  input  logic [LEN_W-1:0] len,
  output logic [NREQ-1:0]  gnt,
  output logic             pulse_out,
  output logic             busy,
  output logic             done
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic               pulse_q, pulse_d;
  logic               done_q, done_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   rrPtr_q, rrPtr_d;
  logic [PTR_W-1:0]   win_q, win_d;

  logic               found;
  logic [PTR_W-1:0]   winner;
  logic [PTR_W-1:0]   idxP;
  int                 idx;

  // Round-robin search: walk upward from rrPtr_q with wrap-around and keep
  // the first active requester. Index arithmetic is done in int so that
  // non-power-of-two NREQ wraps correctly.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    idxP   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rrPtr_q) + i;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      idxP = PTR_W'(idx);
      if (!found && req[idxP]) begin
        found  = 1'b1;
        winner = idxP;
      end
    end
  end

  // Next-state logic. All outputs are registered, so every output has a
  // _d value computed here; inputs only matter on the granting edge, which
  // keeps pulse_out and gnt frozen for the whole burst.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    pulse_d = pulse_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    rrPtr_d = rrPtr_q;
    win_d   = win_q;

    case (state_q)
      IDLE: begin
        gnt_d   = '0;
        pulse_d = 1'b0;
        if (found) begin
          state_d = RUN;
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << winner;
          pulse_d = mode[winner];
          cnt_d   = (len == '0) ? LEN_W'(1) : len;
          win_d   = winner;
        end
      end

      RUN: begin
        // cnt_q holds the cycles remaining including the current one; the
        // zero case cannot occur in normal operation but ends the burst too.
        if (cnt_q <= LEN_W'(1)) begin
          state_d = GAP;
          gnt_d   = '0;
          pulse_d = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          rrPtr_d = (win_q == PTR_W'(NREQ - 1)) ? '0 : win_q + PTR_W'(1);
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end

      GAP: begin
        state_d = IDLE;
        gnt_d   = '0;
        pulse_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        pulse_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State register. Reset wins over everything, including a burst in flight,
  // and never produces a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      rrPtr_q <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      rrPtr_q <= rrPtr_d;
      win_q   <= win_d;
    end
  end

  assign gnt       = gnt_q;
  assign pulse_out = pulse_q;
  assign done      = done_q;
  assign busy      = (state_q == RUN) || (state_q == GAP);

endmodule
